// File: rtl/keyed_lut_lock.sv
// Key-locked datapath: a serially loaded key gates an XOR mask on din and feeds a small LUT.
// Optional macro KEY_PARITY_EN adds the key_par input and an even-parity check on the loaded key.
module keyed_lut_lock #(
    parameter int  XOR_N   = 3,
    parameter int  MUX_SEL = 2,
    localparam int KEY_W   = XOR_N + 2**MUX_SEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    input  logic               key_vld,
    input  logic               key_bit,
`ifdef KEY_PARITY_EN
    input  logic               key_par,
`endif
    input  logic               din_vld,
    input  logic [XOR_N-1:0]   din,
    input  logic [MUX_SEL-1:0] lut_sel,
    output logic [XOR_N-1:0]   dout,
    output logic               lut_out,
    output logic               out_vld,
    output logic               armed,
    output logic               busy,
    output logic               key_err
);

    localparam int LUT_N = 2**MUX_SEL;
    localparam int CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, ERROR} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [KEY_W-1:0]   key;
    logic [CNT_W-1:0]   cnt;
    logic               shift_en;
    logic               last_bit;
    logic               parity_ok;
    logic [LUT_N-1:0]   lut_bits;
    logic [XOR_N-1:0]   key_mask;

    assign lut_bits = key[KEY_W-1:XOR_N];
    assign key_mask = key[XOR_N-1:0];
    assign last_bit = (cnt == CNT_W'(KEY_W - 1));

`ifdef KEY_PARITY_EN
    assign parity_ok = ((^key) == key_par);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ARMED, ERROR: if (key_load) state_nxt = LOAD;
            LOAD:               if (shift_en && last_bit) state_nxt = CHECK;
            CHECK:              state_nxt = parity_ok ? ARMED : ERROR;
            default:            state_nxt = IDLE;
        endcase
    end

    // key_load outranks key_vld, so a restart in LOAD never shifts the bit offered alongside it
    always_comb begin
        busy     = (state == LOAD) || (state == CHECK);
        armed    = (state == ARMED);
        shift_en = (state == LOAD) && !key_load && key_vld;
`ifdef KEY_PARITY_EN
        key_err  = (state == ERROR);
`else
        key_err  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key <= '0;
            cnt <= '0;
        end else if (key_load) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= cnt + CNT_W'(1);
            for (int i = 0; i < KEY_W; i++) begin
                if (cnt == CNT_W'(i)) key[i] <= key_bit;
            end
        end
    end

    // Outputs are forced to zero whenever the lock is not armed, so a half-loaded key never leaks
    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            lut_out <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= din_vld && armed;
            if (!armed) begin
                dout    <= '0;
                lut_out <= 1'b0;
            end else if (din_vld) begin
                dout    <= din ^ key_mask;
                lut_out <= lut_bits[lut_sel];
            end
        end
    end

endmodule

// File: tb/tb_keyed_lut_lock.sv
// Directed self-checking bench for keyed_lut_lock: default 7-bit key instance plus a 16-bit key instance.
// Parity-failure vectors are compiled in only when KEY_PARITY_EN is defined.
module tb_keyed_lut_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       key_load = 1'b0;
    logic       key_vld  = 1'b0;
    logic       key_bit  = 1'b0;
    logic       key_par  = 1'b0;
    logic       din_vld  = 1'b0;
    logic [2:0] din      = '0;
    logic [1:0] lut_sel  = '0;
    logic [2:0] dout;
    logic       lut_out, out_vld, armed, busy, key_err;

    logic       key_load2 = 1'b0;
    logic       key_vld2  = 1'b0;
    logic       key_bit2  = 1'b0;
    logic       key_par2  = 1'b0;
    logic       din_vld2  = 1'b0;
    logic [7:0] din2      = '0;
    logic [2:0] lut_sel2  = '0;
    logic [7:0] dout2;
    logic       lut_out2, out_vld2, armed2, busy2, key_err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keyed_lut_lock dut (
        .clk(clk), .rst(rst),
        .key_load(key_load), .key_vld(key_vld), .key_bit(key_bit),
`ifdef KEY_PARITY_EN
        .key_par(key_par),
`endif
        .din_vld(din_vld), .din(din), .lut_sel(lut_sel),
        .dout(dout), .lut_out(lut_out), .out_vld(out_vld),
        .armed(armed), .busy(busy), .key_err(key_err)
    );

    keyed_lut_lock #(.XOR_N(8), .MUX_SEL(3)) dut16 (
        .clk(clk), .rst(rst),
        .key_load(key_load2), .key_vld(key_vld2), .key_bit(key_bit2),
`ifdef KEY_PARITY_EN
        .key_par(key_par2),
`endif
        .din_vld(din_vld2), .din(din2), .lut_sel(lut_sel2),
        .dout(dout2), .lut_out(lut_out2), .out_vld(out_vld2),
        .armed(armed2), .busy(busy2), .key_err(key_err2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [2:0] d, input logic [1:0] sel);
        din_vld = vld;
        din     = d;
        lut_sel = sel;
        step();
    endtask

    // Pulses key_load, shifts seven bits LSB first, then holds key_vld one extra cycle to prove it is ignored
    task automatic loadKey(input logic [6:0] k, input logic exp_armed, input string tag);
        int busy_n;
        busy_n   = 0;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        if (busy) busy_n++;
        for (int i = 0; i < 7; i++) begin
            key_vld = 1'b1;
            key_bit = k[i];
            step();
            if (busy) busy_n++;
        end
        key_bit = ~key_bit;
        step();
        if (busy) busy_n++;
        key_vld = 1'b0;
        checkOutput({tag, "_busy_cycles"}, busy_n, 8);
        checkOutput({tag, "_armed"}, armed, exp_armed);
    endtask

    initial begin
        logic [3:0]  lut_exp;
        logic [7:0]  lut_exp2;
        logic [15:0] key16;
        int          busy_n;

        rst = 1'b1;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        step();
        checkOutput("rst_out_vld", out_vld, 0);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_lut_out", lut_out, 0);
        checkOutput("rst_armed", armed, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_key_err", key_err, 0);
        rst = 1'b0;

        applyStimulus(1'b1, 3'b111, 2'd0);
        checkOutput("idle_out_vld", out_vld, 0);
        checkOutput("idle_dout", dout, 0);
        din_vld = 1'b0;

        // Bits 1,0,1 | 0,1,1,0 -> mask 3'b101, LUT 0,1,1,0
        loadKey(7'h35, 1'b1, "load1");
        checkOutput("load1_key_err", key_err, 0);
        lut_exp = 4'b0110;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 3'b000, 2'(s));
            checkOutput($sformatf("load1_vld_%0d", s), out_vld, 1);
            checkOutput($sformatf("load1_dout_%0d", s), dout, 3'b101);
            checkOutput($sformatf("load1_lut_%0d", s), lut_out, lut_exp[s]);
        end
        applyStimulus(1'b1, 3'b111, 2'd2);
        checkOutput("load1_dout_111", dout, 3'b010);

        applyStimulus(1'b1, 3'b011, 2'd1);
        checkOutput("pulse1_vld", out_vld, 1);
        checkOutput("pulse1_dout", dout, 3'b110);
        applyStimulus(1'b0, 3'b000, 2'd0);
        checkOutput("gap_vld", out_vld, 0);
        checkOutput("gap_dout_hold", dout, 3'b110);
        checkOutput("gap_lut_hold", lut_out, 1);
        applyStimulus(1'b1, 3'b100, 2'd3);
        checkOutput("pulse2_vld", out_vld, 1);
        checkOutput("pulse2_dout", dout, 3'b001);
        checkOutput("pulse2_lut", lut_out, 0);
        din_vld = 1'b0;

        // Restart after four garbage bits; key_vld is high during the restart cycle too
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_vld = 1'b1;
            key_bit = 1'b1;
            step();
        end
        checkOutput("restart_busy_mid", busy, 1);
        loadKey(7'h4E, 1'b1, "restart");
        lut_exp = 4'b1001;
        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 3'b000, 2'(s));
            checkOutput($sformatf("restart_dout_%0d", s), dout, 3'b110);
            checkOutput($sformatf("restart_lut_%0d", s), lut_out, lut_exp[s]);
        end
        din_vld = 1'b0;

        // Reset on the fifth bit of a load
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_vld = 1'b1;
            key_bit = 1'(i);
            step();
        end
        rst = 1'b1;
        din_vld = 1'b1;
        step();
        rst = 1'b0;
        key_vld = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_armed", armed, 0);
        checkOutput("midrst_out_vld", out_vld, 0);
        checkOutput("midrst_dout", dout, 0);
        checkOutput("midrst_lut", lut_out, 0);
        applyStimulus(1'b1, 3'b101, 2'd1);
        checkOutput("midrst_din_out_vld", out_vld, 0);
        checkOutput("midrst_din_dout", dout, 0);
        din_vld = 1'b0;

`ifdef KEY_PARITY_EN
        key_par = 1'b0;
        loadKey(7'h01, 1'b0, "parity");
        checkOutput("parity_key_err", key_err, 1);
        applyStimulus(1'b1, 3'b111, 2'd0);
        checkOutput("parity_out_vld", out_vld, 0);
        checkOutput("parity_key_err_sticky", key_err, 1);
        din_vld = 1'b0;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        checkOutput("parity_clear_err", key_err, 0);
        checkOutput("parity_clear_busy", busy, 1);
`endif

        // Wide instance: 16-bit key 16'hA5C3 -> mask 8'hC3, LUT 8'hA5
        key16  = 16'hA5C3;
        busy_n = 0;
        key_load2 = 1'b1;
        step();
        key_load2 = 1'b0;
        if (busy2) busy_n++;
        for (int i = 0; i < 16; i++) begin
            key_vld2 = 1'b1;
            key_bit2 = key16[i];
            step();
            if (busy2) busy_n++;
        end
        key_vld2 = 1'b0;
        step();
        if (busy2) busy_n++;
        checkOutput("wide_busy_cycles", busy_n, 17);
        checkOutput("wide_armed", armed2, 1);
        lut_exp2 = 8'hA5;
        for (int s = 0; s < 8; s++) begin
            din_vld2 = 1'b1;
            din2     = 8'h0F + 8'(s);
            lut_sel2 = 3'(s);
            step();
            checkOutput($sformatf("wide_dout_%0d", s), dout2, (8'h0F + 8'(s)) ^ 8'hC3);
            checkOutput($sformatf("wide_lut_%0d", s), lut_out2, lut_exp2[s]);
        end
        din_vld2 = 1'b0;
        step();
        checkOutput("wide_out_vld_drop", out_vld2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
